// File: rtl/taxi_stat_accum_pkg.sv
// Shared types for taxi_stat_accum: scan FSM state encoding and the
// channel-pointer width rule.
package taxi_stat_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Width of the channel pointer for a given channel count: $clog2(cnt),
  // never below one bit so a single-channel build still has a pointer.
  function automatic int ptr_width(input int cnt);
    return (cnt > 1) ? $clog2(cnt) : 1;
  endfunction

endpackage

// File: rtl/taxi_stat_accum.sv
// taxi_stat_accum: per-channel statistic accumulators, flushed as AXI-Stream
// beats (tdata = count, tid = channel id) on a periodic timer or when any
// accumulator reaches its top bit. Zero counters are skipped.
// Build option: define TAXI_STAT_ACCUM_SAT_EN to make accumulators saturate
// at all-ones instead of wrapping.
module taxi_stat_accum
  import taxi_stat_accum_pkg::*;
#(
  parameter int CNT           = 8,
  parameter int INC_W         = 8,
  parameter int DATA_W        = 16,
  parameter int ID_W          = 10,
  parameter int ID_BASE       = 0,
  parameter int UPDATE_PERIOD = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT*INC_W-1:0]   stat_inc,
  input  logic [CNT-1:0]         stat_valid,
  output logic [DATA_W-1:0]      m_axis_stat_tdata,
  output logic [ID_W-1:0]        m_axis_stat_tid,
  output logic                   m_axis_stat_tuser,
  output logic                   m_axis_stat_tvalid,
  input  logic                   m_axis_stat_tready
);

  localparam int PTR_W = ptr_width(CNT);
  localparam int TMR_W = $clog2(UPDATE_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(UPDATE_PERIOD - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CNT - 1);

  logic [DATA_W-1:0] acc     [CNT];
  logic [DATA_W-1:0] inc_ext [CNT];
  logic [DATA_W-1:0] acc_sum [CNT];
  logic [CNT-1:0]    urgent;

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [TMR_W-1:0]  timer;
  logic              flush_pend;
  logic              timer_wrap;
  logic [DATA_W-1:0] acc_sel;
  logic              capture;

`ifdef TAXI_STAT_ACCUM_SAT_EN
  logic [DATA_W:0]   sum_wide [CNT];
`endif

  // Per-channel next value: gated increment added to the accumulator.
  always_comb begin
    for (int i = 0; i < CNT; i++) begin
      inc_ext[i] = stat_valid[i] ? DATA_W'(stat_inc[i*INC_W +: INC_W]) : '0;
`ifdef TAXI_STAT_ACCUM_SAT_EN
      sum_wide[i] = {1'b0, acc[i]} + {1'b0, inc_ext[i]};
      acc_sum[i]  = sum_wide[i][DATA_W] ? '1 : sum_wide[i][DATA_W-1:0];
`else
      acc_sum[i]  = acc[i] + inc_ext[i];
`endif
      urgent[i]   = acc[i][DATA_W-1];
    end
  end

  // Scan decode: the counter under the pointer and whether it is reported.
  always_comb begin
    acc_sel    = acc[ptr];
    capture    = (state == ST_SCAN) && (acc_sel != '0);
    timer_wrap = (timer == TMR_LAST);
  end

  // Accumulators; a captured channel restarts from this cycle's increment
  // so nothing is lost between the snapshot and the restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counters live in flops, not RAM, so every entry is cleared
      // by reset; a RAM-backed array would need a clearing sweep instead.
      for (int i = 0; i < CNT; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < CNT; i++) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (capture && (ptr == PTR_W'(i))) acc[i] <= inc_ext[i];
        else                               acc[i] <= acc_sum[i];
      end
    end
  end

  // Free-running flush timer, 0..UPDATE_PERIOD-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer <= '0;
    else if (timer_wrap) timer <= '0;
    else timer <= timer + TMR_W'(1);
  end

  // Scan/send FSM with output register and pending-flush flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_IDLE;
      ptr                <= '0;
      flush_pend         <= 1'b0;
      m_axis_stat_tdata  <= '0;
      m_axis_stat_tid    <= '0;
      m_axis_stat_tuser  <= 1'b0;
      m_axis_stat_tvalid <= 1'b0;
    end else begin
      // A wrap always wins over a same-cycle clear so no period is missed.
      if (timer_wrap) flush_pend <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (flush_pend || (|urgent)) begin
            state <= ST_SCAN;
            ptr   <= '0;
            if (!timer_wrap) flush_pend <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (capture) begin
            m_axis_stat_tdata  <= acc_sel;
            m_axis_stat_tid    <= ID_W'(ID_BASE) + ID_W'(ptr);
            m_axis_stat_tuser  <= 1'b0;
            m_axis_stat_tvalid <= 1'b1;
            state              <= ST_SEND;
          end else if (ptr == PTR_LAST) begin
            state <= ST_IDLE;
          end else begin
            ptr <= ptr + PTR_W'(1);
          end
        end
        ST_SEND: begin
          if (m_axis_stat_tready) begin
            m_axis_stat_tvalid <= 1'b0;
            if (ptr == PTR_LAST) begin
              state <= ST_IDLE;
            end else begin
              ptr   <= ptr + PTR_W'(1);
              state <= ST_SCAN;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/taxi_stat_accum.md
TAXI_STAT_ACCUM -- requirements
Module: taxi_stat_accum

Interface
REQ-001 Parameter CNT, default 8: number of statistic input channels (1..64).
REQ-002 Parameter INC_W, default 8: per-cycle increment width; SHALL be at most DATA_W-2.
REQ-003 Parameter DATA_W, default 16: accumulator and output tdata width.
REQ-004 Parameter ID_W, default 10: output tid width.
REQ-005 Parameter ID_BASE, default 0: tid of channel 0; channel i uses ID_BASE+i.
REQ-006 Parameter UPDATE_PERIOD, default 1024: cycles between periodic flushes; minimum 2.
REQ-007 clk  input  1  sole clock; all logic is rising-edge.
REQ-008 rst  input  1  reset, asynchronous assert, active-high.
REQ-009 stat_inc  input  CNT*INC_W  increment for channel i in bits [i*INC_W +: INC_W].
REQ-010 stat_valid  input  CNT  qualifies stat_inc per channel.
REQ-011 m_axis_stat  taxi_axis_if source  tdata DATA_W, tid ID_W, tuser 1, tvalid/tready; no tkeep, no tlast.

Function
REQ-012 The block SHALL add stat_inc[i] to accumulator acc[i] in the cycle stat_valid[i]=1, for every channel, with no input backpressure.
REQ-013 A free-running timer SHALL count 0..UPDATE_PERIOD-1 and wrap; the wrap cycle SHALL set flush_pend.
REQ-014 Channel i SHALL be marked urgent while acc[i] bit DATA_W-1 is set.
REQ-015 FSM states: IDLE, SCAN, SEND.
REQ-016 IDLE->SCAN when flush_pend=1 or any urgent flag; ptr loads 0 and flush_pend clears.
REQ-017 SCAN, acc[ptr]=0: ptr increments, one channel per cycle; at ptr=CNT-1 go to IDLE.
REQ-018 SCAN, acc[ptr]!=0: capture acc[ptr] into tdata, tid=ID_BASE+ptr, tuser=0, assert tvalid next cycle, go to SEND.
REQ-019 In the capture cycle acc[ptr] SHALL load the same-cycle increment (or 0), so no increment is lost or double-counted.
REQ-020 SEND SHALL hold tdata/tid/tvalid stable until tready=1; on handshake advance ptr (or go to IDLE after CNT-1) in the same cycle.
REQ-021 A timer wrap during SCAN/SEND SHALL set flush_pend, serviced by a new scan after return to IDLE.
REQ-022 Capture-to-tvalid latency SHALL be one cycle; idle-to-first-beat latency at most CNT+1 cycles after trigger.
REQ-023 Beats SHALL be emitted in ascending channel order within a scan; zero-valued beats SHALL never be emitted.

Reset
REQ-024 rst=1 SHALL clear immediately: all acc, timer, ptr, flush_pend, tvalid=0, tdata=0, tid=0, tuser=0, state IDLE.
REQ-025 Reset during SEND SHALL drop the pending beat without handshake; counts accumulated before reset are discarded.

Configuration
REQ-026 Macro TAXI_STAT_ACCUM_SAT_EN defined: acc[i] saturates at all-ones on overflow (sustained backpressure).
REQ-027 Macro undefined: acc[i] wraps modulo 2^DATA_W; no saturation logic is generated.

Structure
REQ-028 Package taxi_stat_accum_pkg SHALL hold the FSM state enum typedef and the width constant for ptr ($clog2(CNT), min 1).
REQ-029 The block is a single module with no sub-modules; output feeds taxi_axis_arb_mux ahead of the statistics XFCP module.

Verification
REQ-030 CNT=4, UPDATE_PERIOD=64, ch1 inc 3 for 10 cycles, tready=1 -> one beat tdata=30, tid=ID_BASE+1 after the next timer wrap.
REQ-031 ch0=5 and ch3=7 pending, others 0 -> two beats, tid order 0 then 3, no beats for ch1/ch2.
REQ-032 DATA_W=16, INC_W=8, ch2 inc 255 every cycle, timer far from wrap -> urgent flush when acc>=32768, well before period end; sum of beats equals total input.
REQ-033 tready=0 for 20 cycles in SEND while ch0 keeps incrementing by 1 -> tdata stable; next scan reports the 20 further counts exactly.
REQ-034 With TAXI_STAT_ACCUM_SAT_EN, tready=0 indefinitely, ch0 inc 255/cycle -> captured-after-release acc reads 16'hFFFF; without macro it wraps.
REQ-035 Assert rst mid-SEND -> tvalid drops same cycle, all acc read 0 afterward, first post-reset beat reflects only post-reset increments.
